// File: rtl/cvxif_ooo_fu.sv
// CV-X-IF offload functional unit: forwards instructions to a coprocessor, tracks
// accepted offloads and turns rejected ones into illegal-instruction writebacks.

package cvxif_ooo_fu_pkg;

    localparam int unsigned CVXIF_XLEN      = 64;
    localparam int unsigned CVXIF_ID_W      = 3;
    localparam int unsigned CVXIF_NR_RS_MAX = 3;

    localparam logic [CVXIF_XLEN-1:0] ILLEGAL_INSTR = CVXIF_XLEN'(2);

    typedef struct packed {
        logic [31:0]                                instr;
        logic [1:0]                                 mode;
        logic [CVXIF_ID_W-1:0]                      id;
        logic [CVXIF_NR_RS_MAX-1:0][CVXIF_XLEN-1:0] rs;
        logic [CVXIF_NR_RS_MAX-1:0]                 rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic [CVXIF_ID_W-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [CVXIF_ID_W-1:0] id;
        logic [CVXIF_XLEN-1:0] data;
        logic                  we;
        logic                  exc;
        logic [5:0]            exccode;
    } x_result_t;

    typedef struct packed {
        logic         x_issue_valid;
        x_issue_req_t x_issue_req;
        logic         x_commit_valid;
        x_commit_t    x_commit;
        logic         x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic      x_issue_ready;
        logic      x_issue_accept;
        logic      x_result_valid;
        x_result_t x_result;
    } cvxif_resp_t;

    typedef struct packed {
        logic [CVXIF_XLEN-1:0] cause;
        logic [CVXIF_XLEN-1:0] tval;
        logic [CVXIF_XLEN-1:0] tval2;
        logic [31:0]           tinst;
        logic                  gva;
        logic                  valid;
    } exception_t;

endpackage

module cvxif_ooo_fu
    import cvxif_ooo_fu_pkg::*;
#(
    parameter int unsigned IllegalDepth   = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned NrRs           = 2,
    parameter bit          TvalEn         = 1'b1,
    parameter int unsigned TransIdBits    = 3,
    parameter int unsigned XLEN           = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   x_valid_i,
    output logic                   x_ready_o,
    input  logic [TransIdBits-1:0] trans_id_i,
    input  logic [31:0]            instr_i,
    input  logic [1:0]             priv_lvl_i,
    input  logic [NrRs*XLEN-1:0]   rs_i,
    output cvxif_req_t             cvxif_req_o,
    input  cvxif_resp_t            cvxif_resp_i,
    output logic                   x_valid_o,
    output logic [TransIdBits-1:0] x_trans_id_o,
    output logic [XLEN-1:0]        x_result_o,
    output logic                   x_we_o,
    output exception_t             x_exception_o,
    output logic                   busy_o
);

    localparam int unsigned PTR_W = $clog2(IllegalDepth);
    localparam int unsigned CNT_W = $clog2(MaxOutstanding + 1);

    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MaxOutstanding);

    logic [TransIdBits-1:0] fifo_id_q    [IllegalDepth];
    logic [31:0]            fifo_instr_q [IllegalDepth];
    logic [PTR_W:0]         wr_ptr_q;
    logic [PTR_W:0]         rd_ptr_q;
    logic [CNT_W-1:0]       outstanding_q;

    logic                   queue_empty;
    logic                   queue_full;
    logic                   issue_ok;
    logic                   issue_valid;
    logic                   handshake;
    logic                   push;
    logic                   pop;
    logic                   inc;
    logic                   dec;
    logic                   result_valid;
    logic [TransIdBits-1:0] head_id;
    logic [31:0]            head_instr;

    // Extra pointer bit separates a full queue from an empty one.
    assign queue_empty = (wr_ptr_q == rd_ptr_q);
    assign queue_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign issue_ok     = !queue_full && (outstanding_q < CNT_MAX);
    assign issue_valid  = x_valid_i && issue_ok;
    assign x_ready_o    = cvxif_resp_i.x_issue_ready && issue_ok;
    assign handshake    = x_valid_i && x_ready_o;
    assign result_valid = cvxif_resp_i.x_result_valid;

    assign push = handshake && !cvxif_resp_i.x_issue_accept;
    assign pop  = !result_valid && !queue_empty;
    assign inc  = handshake && cvxif_resp_i.x_issue_accept;
    assign dec  = result_valid && (outstanding_q != '0);

    assign head_id    = fifo_id_q[rd_ptr_q[PTR_W-1:0]];
    assign head_instr = fifo_instr_q[rd_ptr_q[PTR_W-1:0]];

    assign busy_o = (outstanding_q != '0) || !queue_empty;

    // Issue/commit request; payload is zero unless the issue is valid.
    always_comb begin
        cvxif_req_o                = '0;
        cvxif_req_o.x_result_ready = 1'b1;
        cvxif_req_o.x_issue_valid  = issue_valid;
        if (issue_valid) begin
            cvxif_req_o.x_issue_req.instr = instr_i;
            cvxif_req_o.x_issue_req.mode  = priv_lvl_i;
            cvxif_req_o.x_issue_req.id    = CVXIF_ID_W'(trans_id_i);
            for (int unsigned i = 0; i < NrRs; i++) begin
                cvxif_req_o.x_issue_req.rs[i]       = CVXIF_XLEN'(rs_i[i*XLEN +: XLEN]);
                cvxif_req_o.x_issue_req.rs_valid[i] = 1'b1;
            end
        end
        cvxif_req_o.x_commit_valid       = handshake;
        cvxif_req_o.x_commit.id          = CVXIF_ID_W'(trans_id_i);
        cvxif_req_o.x_commit.commit_kill = 1'b0;
    end

    // Writeback mux: coprocessor result wins over the illegal queue head.
    always_comb begin
        x_valid_o     = 1'b0;
        x_trans_id_o  = '0;
        x_result_o    = '0;
        x_we_o        = 1'b0;
        x_exception_o = '0;
        if (result_valid) begin
            x_valid_o           = 1'b1;
            x_trans_id_o        = TransIdBits'(cvxif_resp_i.x_result.id);
            x_result_o          = XLEN'(cvxif_resp_i.x_result.data);
            x_we_o              = cvxif_resp_i.x_result.we;
            x_exception_o.valid = cvxif_resp_i.x_result.exc;
            x_exception_o.cause = CVXIF_XLEN'(cvxif_resp_i.x_result.exccode);
        end else if (!queue_empty) begin
            x_valid_o           = 1'b1;
            x_trans_id_o        = head_id;
            x_exception_o.valid = 1'b1;
            x_exception_o.cause = ILLEGAL_INSTR;
            if (TvalEn) begin
                x_exception_o.tval = CVXIF_XLEN'(head_instr);
            end
        end
    end

    // Queue storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            fifo_id_q[wr_ptr_q[PTR_W-1:0]]    <= trans_id_i;
            fifo_instr_q[wr_ptr_q[PTR_W-1:0]] <= instr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (inc && !dec) begin
                outstanding_q <= outstanding_q + CNT_ONE;
            end else if (dec && !inc) begin
                outstanding_q <= outstanding_q - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cvxif_ooo_fu.sv
// Directed bench for cvxif_ooo_fu: inputs driven on the falling edge, checks 1ns later.

module tb_cvxif_ooo_fu;
    import cvxif_ooo_fu_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic         x_valid_i;
    logic         x_ready_o;
    logic [2:0]   trans_id_i;
    logic [31:0]  instr_i;
    logic [1:0]   priv_lvl_i;
    logic [127:0] rs_i;
    cvxif_req_t   cvxif_req_o;
    cvxif_resp_t  cvxif_resp_i;
    logic         x_valid_o;
    logic [2:0]   x_trans_id_o;
    logic [63:0]  x_result_o;
    logic         x_we_o;
    exception_t   x_exception_o;
    logic         busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    cvxif_ooo_fu dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .x_valid_i    (x_valid_i),
        .x_ready_o    (x_ready_o),
        .trans_id_i   (trans_id_i),
        .instr_i      (instr_i),
        .priv_lvl_i   (priv_lvl_i),
        .rs_i         (rs_i),
        .cvxif_req_o  (cvxif_req_o),
        .cvxif_resp_i (cvxif_resp_i),
        .x_valid_o    (x_valid_o),
        .x_trans_id_o (x_trans_id_o),
        .x_result_o   (x_result_o),
        .x_we_o       (x_we_o),
        .x_exception_o(x_exception_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and return all inputs to idle.
    task automatic cyc();
        @(negedge clk_i);
        x_valid_i    = 1'b0;
        clear_i      = 1'b0;
        trans_id_i   = '0;
        instr_i      = '0;
        cvxif_resp_i = '0;
        cvxif_resp_i.x_issue_ready = 1'b1;
    endtask

    task automatic offload(input logic [2:0] id, input logic [31:0] ins, input logic acc);
        x_valid_i  = 1'b1;
        trans_id_i = id;
        instr_i    = ins;
        cvxif_resp_i.x_issue_accept = acc;
    endtask

    task automatic result(input logic [2:0] id, input logic [63:0] d, input logic we,
                          input logic e, input logic [5:0] code);
        cvxif_resp_i.x_result_valid   = 1'b1;
        cvxif_resp_i.x_result.id      = id;
        cvxif_resp_i.x_result.data    = d;
        cvxif_resp_i.x_result.we      = we;
        cvxif_resp_i.x_result.exc     = e;
        cvxif_resp_i.x_result.exccode = code;
    endtask

    initial begin
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        x_valid_i    = 1'b0;
        trans_id_i   = '0;
        instr_i      = '0;
        priv_lvl_i   = 2'b11;
        rs_i         = {64'h0000_0000_BBBB_BBBB, 64'h0000_0000_AAAA_AAAA};
        cvxif_resp_i = '0;

        // Reset state; a coprocessor result still passes through during reset
        @(negedge clk_i); #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", x_valid_o, 0);
        cyc(); result(3'd4, 64'h99, 1'b1, 1'b0, 6'd0); #1;
        chk("rst_res_valid", x_valid_o, 1);
        chk("rst_res_data", x_result_o, 64'h99);
        cyc(); rst_ni = 1'b1;

        // Accepted offload, result three cycles later
        cyc(); offload(3'd2, 32'h0000_002B, 1'b1); #1;
        chk("t1_ready", x_ready_o, 1);
        chk("t1_issue_valid", cvxif_req_o.x_issue_valid, 1);
        chk("t1_issue_instr", cvxif_req_o.x_issue_req.instr, 32'h0000_002B);
        chk("t1_issue_id", cvxif_req_o.x_issue_req.id, 2);
        chk("t1_issue_mode", cvxif_req_o.x_issue_req.mode, 2'b11);
        chk("t1_rs0", cvxif_req_o.x_issue_req.rs[0], 64'h0000_0000_AAAA_AAAA);
        chk("t1_rs1", cvxif_req_o.x_issue_req.rs[1], 64'h0000_0000_BBBB_BBBB);
        chk("t1_rs_valid", cvxif_req_o.x_issue_req.rs_valid, 3'b011);
        chk("t1_commit_valid", cvxif_req_o.x_commit_valid, 1);
        chk("t1_commit_id", cvxif_req_o.x_commit.id, 2);
        chk("t1_result_ready", cvxif_req_o.x_result_ready, 1);
        chk("t1_no_wb", x_valid_o, 0);
        cyc(); #1;
        chk("t1_busy", busy_o, 1);
        chk("t1_idle_issue_valid", cvxif_req_o.x_issue_valid, 0);
        chk("t1_idle_instr", cvxif_req_o.x_issue_req.instr, 0);
        cyc();
        cyc(); result(3'd2, 64'h55, 1'b1, 1'b0, 6'd0); #1;
        chk("t1_wb_valid", x_valid_o, 1);
        chk("t1_wb_id", x_trans_id_o, 2);
        chk("t1_wb_data", x_result_o, 64'h55);
        chk("t1_wb_we", x_we_o, 1);
        chk("t1_wb_exc", x_exception_o.valid, 0);
        cyc(); #1;
        chk("t1_busy_fall", busy_o, 0);
        chk("t1_wb_idle", x_valid_o, 0);

        // Rejected offload becomes an illegal-instruction writeback next cycle
        cyc(); offload(3'd5, 32'h0000_700B, 1'b0); #1;
        chk("t2_ready", x_ready_o, 1);
        chk("t2_no_bypass", x_valid_o, 0);
        cyc(); #1;
        chk("t2_valid", x_valid_o, 1);
        chk("t2_id", x_trans_id_o, 5);
        chk("t2_cause", x_exception_o.cause, 2);
        chk("t2_tval", x_exception_o.tval, 64'h700B);
        chk("t2_exc_valid", x_exception_o.valid, 1);
        chk("t2_we", x_we_o, 0);
        chk("t2_result", x_result_o, 0);
        cyc(); #1;
        chk("t2_drained", x_valid_o, 0);
        chk("t2_busy", busy_o, 0);

        // Fill the queue while results hold off the pops
        for (int i = 1; i <= 4; i++) begin
            cyc(); offload(3'(i), 32'h0000_000B | (32'(i) << 12), 1'b0);
            result(3'd0, 64'h11, 1'b0, 1'b1, 6'd11); #1;
            chk("t3_fill_ready", x_ready_o, 1);
            chk("t3_res_id", x_trans_id_o, 0);
            chk("t3_res_cause", x_exception_o.cause, 11);
        end
        cyc(); offload(3'd6, 32'h0000_600B, 1'b0);
        result(3'd0, 64'h11, 1'b0, 1'b1, 6'd11); #1;
        chk("t3_full_ready", x_ready_o, 0);
        chk("t3_full_issue", cvxif_req_o.x_issue_valid, 0);
        chk("t3_full_commit", cvxif_req_o.x_commit_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(); #1;
            chk("t3_drain_valid", x_valid_o, 1);
            chk("t3_drain_id", x_trans_id_o, 64'(i));
            chk("t3_drain_tval", x_exception_o.tval, 64'h000B | (64'(i) << 12));
        end
        cyc(); #1;
        chk("t3_empty", x_valid_o, 0);
        chk("t3_busy", busy_o, 0);

        // Outstanding limit
        for (int i = 0; i < 4; i++) begin
            cyc(); offload(3'(i), 32'h0000_002B, 1'b1); #1;
            chk("t4_fill_ready", x_ready_o, 1);
        end
        cyc(); offload(3'd4, 32'h0000_002B, 1'b1); #1;
        chk("t4_max_ready", x_ready_o, 0);
        chk("t4_max_issue", cvxif_req_o.x_issue_valid, 0);
        chk("t4_max_commit", cvxif_req_o.x_commit_valid, 0);
        chk("t4_busy", busy_o, 1);
        cyc(); offload(3'd4, 32'h0000_002B, 1'b1); result(3'd0, 64'hA, 1'b1, 1'b0, 6'd0); #1;
        chk("t4_same_cycle_ready", x_ready_o, 0);
        chk("t4_res_valid", x_valid_o, 1);
        cyc(); offload(3'd4, 32'h0000_002B, 1'b1); #1;
        chk("t4_restored_ready", x_ready_o, 1);
        chk("t4_restored_issue", cvxif_req_o.x_issue_valid, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); result(3'(i + 1), 64'hB, 1'b1, 1'b0, 6'd0);
        end
        cyc(); #1;
        chk("t4_busy_done", busy_o, 0);

        // Result and rejection in one cycle on a non-empty queue, then push+pop
        cyc(); offload(3'd1, 32'h0000_100B, 1'b0); #1;
        chk("t5_ready", x_ready_o, 1);
        cyc(); offload(3'd3, 32'h0000_300B, 1'b0); result(3'd6, 64'h66, 1'b1, 1'b0, 6'd0); #1;
        chk("t5_res_id", x_trans_id_o, 6);
        chk("t5_res_data", x_result_o, 64'h66);
        cyc(); offload(3'd4, 32'h0000_400B, 1'b0); #1;
        chk("t5_pushpop_ready", x_ready_o, 1);
        chk("t5_head1_id", x_trans_id_o, 1);
        chk("t5_head1_tval", x_exception_o.tval, 64'h100B);
        cyc(); #1;
        chk("t5_head3_id", x_trans_id_o, 3);
        chk("t5_head3_tval", x_exception_o.tval, 64'h300B);
        cyc(); #1;
        chk("t5_head4_id", x_trans_id_o, 4);
        chk("t5_head4_tval", x_exception_o.tval, 64'h400B);
        cyc(); #1;
        chk("t5_empty", x_valid_o, 0);
        chk("t5_busy", busy_o, 0);

        // Synchronous clear with queued entries and outstanding offloads
        for (int i = 0; i < 3; i++) begin
            cyc(); offload(3'(i), 32'h0000_002B, 1'b1);
        end
        cyc(); offload(3'd5, 32'h0000_500B, 1'b0);
        cyc(); offload(3'd6, 32'h0000_600B, 1'b0); result(3'd0, 64'h1, 1'b1, 1'b0, 6'd0); #1;
        chk("t6_res_id", x_trans_id_o, 0);
        cyc(); clear_i = 1'b1; offload(3'd3, 32'h0000_002B, 1'b1); #1;
        chk("t6_clr_cycle_valid", x_valid_o, 1);
        chk("t6_clr_cycle_id", x_trans_id_o, 5);
        chk("t6_clr_cycle_ready", x_ready_o, 1);
        chk("t6_clr_cycle_busy", busy_o, 1);
        cyc(); #1;
        chk("t6_cleared_busy", busy_o, 0);
        chk("t6_cleared_valid", x_valid_o, 0);
        cyc(); #1;
        chk("t6_cleared_valid2", x_valid_o, 0);

        // Asynchronous reset mid-operation
        cyc(); offload(3'd1, 32'h0000_002B, 1'b1);
        cyc(); offload(3'd7, 32'h0000_700B, 1'b0);
        cyc(); rst_ni = 1'b0; #1;
        chk("t7_rst_valid", x_valid_o, 0);
        chk("t7_rst_busy", busy_o, 0);
        cyc(); rst_ni = 1'b1; #1;
        chk("t7_post_valid", x_valid_o, 0);
        chk("t7_post_busy", busy_o, 0);
        cyc(); #1;
        chk("t7_post_valid2", x_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
